dmem_arbiter: RTL

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arb_pkg.sv | 14 +
 rtl/dmem_arb_starve_ctr.sv | 33 +++
 rtl/dmem_arbiter.sv | 110 +++++++++++
 3 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter.
//   owner_e          : which requester owns the read data returning next cycle
//   STARVE_LIMIT_DEF : default number of consecutive DMA denials before a forced slot
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_DMA  = 2'd2
  } owner_e;

  localparam int STARVE_LIMIT_DEF = 8;

endpackage

// File: rtl/dmem_arb_starve_ctr.sv
// Saturating DMA starvation counter.
// Counts cycles in which the DMA is requesting but not granted, saturating at
// LIMIT. Cleared on any DMA grant, whenever the DMA is not requesting, and
// during reset.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_dma_req      : DMA request this cycle
//   i_dma_gnt      : DMA granted this cycle
//   o_at_limit     : counter has reached LIMIT (DMA slot must be forced)
module dmem_arb_starve_ctr #(
  parameter int LIMIT = dmem_arb_pkg::STARVE_LIMIT_DEF
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_dma_req,
  input  logic i_dma_gnt,
  output logic o_at_limit
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  assign o_at_limit = (cnt == CW'(LIMIT));

  always_ff @(posedge i_clk) begin
    if (i_reset || !i_dma_req || i_dma_gnt) begin
      cnt <= '0;
    end else if (!o_at_limit) begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester data-memory arbiter (pipeline core vs. DMA/debug loader).
// The core normally wins; a DMA requester denied STARVE_LIMIT consecutive
// cycles gets one forced slot, stalling the core for that single cycle.
// Grants drive the memory port combinationally; read data returns one cycle
// later and is flagged by the owner's rvalid strobe.
//   i_clk, i_reset       : clock, synchronous active-high reset
//   i_core_*             : core M-stage request (byte address, data, mask)
//   o_core_stall/rvalid/rdata : core stall, read strobe, read data
//   i_dma_*              : DMA request fields, held until o_dma_gnt
//   o_dma_gnt/rvalid/rdata : DMA grant, read strobe, read data
//   o_mem_*              : single memory port, word-addressed
//   i_mem_rdata          : memory read data, one cycle after a read
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_core_req,
  input  logic              i_core_we,
  input  logic [31:0]       i_core_addr,
  input  logic [31:0]       i_core_wdata,
  input  logic [3:0]        i_core_bmask,
  output logic              o_core_stall,
  output logic              o_core_rvalid,
  output logic [31:0]       o_core_rdata,
  input  logic              i_dma_req,
  input  logic              i_dma_we,
  input  logic [31:0]       i_dma_addr,
  input  logic [31:0]       i_dma_wdata,
  input  logic [3:0]        i_dma_bmask,
  output logic              o_dma_gnt,
  output logic              o_dma_rvalid,
  output logic [31:0]       o_dma_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic [3:0]        o_mem_bmask,
  input  logic [31:0]       i_mem_rdata
);

  logic   at_limit;
  logic   force_dma;
  logic   core_gnt;
  logic   dma_gnt;
  owner_e rd_owner_next;
  owner_e rd_owner_p1;

  // Bits outside the word address are intentionally dropped.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{i_core_addr[31:ADDR_W+2], i_core_addr[1:0],
                              i_dma_addr[31:ADDR_W+2], i_dma_addr[1:0]};

  dmem_arb_starve_ctr #(
    .LIMIT(STARVE_LIMIT)
  ) u_starve_ctr (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_dma_req (i_dma_req),
    .i_dma_gnt (dma_gnt),
    .o_at_limit(at_limit)
  );

  // Grant decision; everything is gated with reset so nothing reaches memory.
  assign force_dma    = i_dma_req && at_limit;
  assign dma_gnt      = !i_reset && i_dma_req && (!i_core_req || at_limit);
  assign core_gnt     = !i_reset && i_core_req && !force_dma;
  assign o_core_stall = !i_reset && i_core_req && force_dma;
  assign o_dma_gnt    = dma_gnt;

  always_comb begin
    o_mem_en      = 1'b0;
    o_mem_we      = 1'b0;
    o_mem_addr    = '0;
    o_mem_wdata   = '0;
    o_mem_bmask   = '0;
    rd_owner_next = OWN_NONE;
    if (dma_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_dma_we;
      o_mem_addr  = i_dma_addr[ADDR_W+1:2];
      o_mem_wdata = i_dma_wdata;
      o_mem_bmask = i_dma_bmask;
      if (!i_dma_we) rd_owner_next = OWN_DMA;
    end else if (core_gnt) begin
      o_mem_en    = 1'b1;
      o_mem_we    = i_core_we;
      o_mem_addr  = i_core_addr[ADDR_W+1:2];
      o_mem_wdata = i_core_wdata;
      o_mem_bmask = i_core_bmask;
      if (!i_core_we) rd_owner_next = OWN_CORE;
    end
  end

  // Stage p0 -> p1: remember who owns the read data returning next cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) rd_owner_p1 <= OWN_NONE;
    else         rd_owner_p1 <= rd_owner_next;
  end

  // A reset arriving between grant and return suppresses the strobe.
  assign o_core_rvalid = !i_reset && (rd_owner_p1 == OWN_CORE);
  assign o_dma_rvalid  = !i_reset && (rd_owner_p1 == OWN_DMA);
  assign o_core_rdata  = i_mem_rdata;
  assign o_dma_rdata   = i_mem_rdata;

endmodule
